// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter with a one-shot launch handshake.
// Bytes leave one at a time; the next launch waits for the transmitter's done pulse.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          i_Clock,
  input  logic          i_Rst_L,
  input  logic          i_Wr_DV,
  input  logic [7:0]    i_Wr_Byte,
  input  logic          i_Flush,
  output logic          o_Full,
  output logic          o_Empty,
  output logic [AW:0]   o_Count,
  output logic          o_Overflow,
  output logic          o_TX_DV,
  output logic [7:0]    o_TX_Byte,
  input  logic          i_TX_Active,
  input  logic          i_TX_Done
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [AW-1:0] PTR_ONE = 1;
  localparam logic [AW:0]   CNT_ONE = 1;
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   count_q;
  logic [AW:0]   count_d;
  logic          full_q;
  logic          empty_q;
  logic          ovf_q;
  logic          dv_q;
  logic [7:0]    byte_q;
  state_t        state_q;
  state_t        state_d;
  logic          launch;
  logic          wr_acc;
  logic          wr_rej;
  logic          tx_active_unused;

  // Sequencing depends only on the done pulse, never the busy level.
  assign tx_active_unused = i_TX_Active;

  assign wr_acc = i_Wr_DV && !full_q && !i_Flush;
  assign wr_rej = i_Wr_DV && full_q && !i_Flush;

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!empty_q && !i_Flush) begin
          launch  = 1'b1;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (i_TX_Done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    count_d = count_q;
    if (i_Flush) begin
      count_d = '0;
    end else if (wr_acc && !launch) begin
      count_d = count_q + CNT_ONE;
    end else if (launch && !wr_acc) begin
      count_d = count_q - CNT_ONE;
    end
  end

  always_ff @(posedge i_Clock) begin
    if (wr_acc) mem[wr_ptr_q] <= i_Wr_Byte;
  end

  always_ff @(posedge i_Clock or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      ovf_q    <= 1'b0;
      dv_q     <= 1'b0;
      byte_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      full_q  <= (count_d == CNT_MAX);
      empty_q <= (count_d == '0);
      ovf_q   <= wr_rej;
      dv_q    <= launch;
      if (launch) byte_q <= mem[rd_ptr_q];
      if (i_Flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (wr_acc) wr_ptr_q <= wr_ptr_q + PTR_ONE;
        if (launch) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  assign o_Full     = full_q;
  assign o_Empty    = empty_q;
  assign o_Count    = count_q;
  assign o_Overflow = ovf_q;
  assign o_TX_DV    = dv_q;
  assign o_TX_Byte  = byte_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: vector table, scoreboard and
// hand-written full/flush/reset sequences against a small TX model.
module tb_uart_tx_fifo;

  localparam int DEPTH = 16;
  localparam int AW = $clog2(DEPTH);

  logic          i_Clock = 1'b0;
  logic          i_Rst_L;
  logic          i_Wr_DV;
  logic [7:0]    i_Wr_Byte;
  logic          i_Flush;
  logic          o_Full;
  logic          o_Empty;
  logic [AW:0]   o_Count;
  logic          o_Overflow;
  logic          o_TX_DV;
  logic [7:0]    o_TX_Byte;
  logic          i_TX_Active;
  logic          i_TX_Done;

  uart_tx_fifo #(.DEPTH(DEPTH)) dut (
    .i_Clock     (i_Clock),
    .i_Rst_L     (i_Rst_L),
    .i_Wr_DV     (i_Wr_DV),
    .i_Wr_Byte   (i_Wr_Byte),
    .i_Flush     (i_Flush),
    .o_Full      (o_Full),
    .o_Empty     (o_Empty),
    .o_Count     (o_Count),
    .o_Overflow  (o_Overflow),
    .o_TX_DV     (o_TX_DV),
    .o_TX_Byte   (o_TX_Byte),
    .i_TX_Active (i_TX_Active),
    .i_TX_Done   (i_TX_Done)
  );

  always #5 i_Clock = ~i_Clock;

  typedef struct {
    logic [7:0] data;
    int         exp_lat;
    int         exp_cnt1;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t       vecs [4];
  logic [7:0] exp_q [$];
  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;
  int dv_count = 0;
  int dv_cyc = 0;
  int ovf_cnt = 0;
  int done_cyc = 0;
  bit done_pending = 0;
  bit chk_done_lat = 0;
  bit prev_dv = 0;
  bit tx_en = 0;
  int tx_delay = 3;
  int tx_cnt = 0;
  int kick_req = 0;
  int kick_ack = 0;

  always @(posedge i_Clock) cyc <= cyc + 1;

  // Output monitor, scoreboard and transmitter model
  always @(negedge i_Clock) begin
    i_TX_Active = 1'($urandom_range(0, 1));
    if (!i_Rst_L) begin
      prev_dv = 0;
      tx_cnt = 0;
      i_TX_Done = 1'b0;
      done_pending = 0;
    end else begin
      i_TX_Done = 1'b0;
      if (o_Overflow) ovf_cnt++;
      if (o_TX_DV) begin
        dv_count++;
        dv_cyc = cyc;
        ncmp++;
        if (prev_dv) begin
          nfail++;
          $display("FAIL dv_consecutive: got DV high two cycles at cyc %0d, want single", cyc);
        end
        ncmp++;
        if (exp_q.size() == 0) begin
          nfail++;
          $display("FAIL unexpected_dv: got byte %02h, want no launch", o_TX_Byte);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (o_TX_Byte !== e) begin
            nfail++;
            $display("FAIL tx_byte: got %02h want %02h", o_TX_Byte, e);
          end
        end
        if (chk_done_lat && done_pending) begin
          ncmp++;
          if (cyc - done_cyc != 2) begin
            nfail++;
            $display("FAIL done_to_dv: got %0d want 2", cyc - done_cyc);
          end
        end
        done_pending = 0;
        if (tx_en) tx_cnt = tx_delay;
      end
      prev_dv = o_TX_DV;
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          i_TX_Done = 1'b1;
          done_cyc = cyc;
          done_pending = 1;
        end
      end else if (kick_req != kick_ack) begin
        kick_ack = kick_req;
        i_TX_Done = 1'b1;
        done_cyc = cyc;
        done_pending = 1;
      end
    end
  end

  task automatic tick();
    @(posedge i_Clock);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_dv(input int target, input int budget, input string nm);
    int i = 0;
    while (dv_count < target && i < budget) begin
      @(negedge i_Clock);
      #1;
      i++;
    end
    ncmp++;
    if (dv_count < target) begin
      nfail++;
      $display("FAIL %s: timeout dv_count %0d want %0d", nm, dv_count, target);
    end
  endtask

  task automatic wait_drain(input int budget, input string nm);
    int i = 0;
    while (exp_q.size() > 0 && i < budget) begin
      @(negedge i_Clock);
      #1;
      i++;
    end
    ncmp++;
    if (exp_q.size() > 0) begin
      nfail++;
      $display("FAIL %s: timeout %0d bytes left want 0", nm, exp_q.size());
    end
  endtask

  task automatic wr(input logic [7:0] b, input bit expect_acc);
    i_Wr_DV = 1'b1;
    i_Wr_Byte = b;
    if (expect_acc) exp_q.push_back(b);
    tick();
    i_Wr_DV = 1'b0;
  endtask

  initial begin
    int n;
    int o;
    int wc;
    int v;
    int g;

    vecs[0] = '{data: 8'hA5, exp_lat: 2, exp_cnt1: 1, exp_byte: 8'hA5};
    vecs[1] = '{data: 8'h00, exp_lat: 2, exp_cnt1: 1, exp_byte: 8'h00};
    vecs[2] = '{data: 8'hFF, exp_lat: 2, exp_cnt1: 1, exp_byte: 8'hFF};
    vecs[3] = '{data: 8'h5A, exp_lat: 2, exp_cnt1: 1, exp_byte: 8'h5A};

    i_Rst_L = 1'b0;
    i_Wr_DV = 1'b0;
    i_Wr_Byte = 8'h00;
    i_Flush = 1'b0;
    i_TX_Done = 1'b0;
    i_TX_Active = 1'b0;
    repeat (3) tick();
    chk("rst_dv", o_TX_DV, 0);
    chk("rst_byte", o_TX_Byte, 8'h00);
    chk("rst_full", o_Full, 0);
    chk("rst_empty", o_Empty, 1);
    chk("rst_count", o_Count, 0);
    chk("rst_ovf", o_Overflow, 0);
    i_Rst_L = 1'b1;
    tick();

    // Single-byte vectors
    tx_en = 1;
    tx_delay = 3;
    for (int k = 0; k < 4; k++) begin
      n = dv_count;
      wc = cyc;
      wr(vecs[k].data, 1);
      chk("cnt_after_wr", o_Count, vecs[k].exp_cnt1);
      wait_dv(n + 1, 10, "single_dv");
      chk("single_lat", dv_cyc - wc, vecs[k].exp_lat);
      repeat (10) tick();
      chk("single_cnt0", o_Count, 0);
      chk("single_empty", o_Empty, 1);
      chk("single_hold", o_TX_Byte, vecs[k].exp_byte);
      chk("single_ndv", dv_count - n, 1);
    end

    // Ordering with slow transmitter
    tx_delay = 100;
    n = dv_count;
    wc = cyc;
    wr(8'h01, 1);
    wr(8'h02, 1);
    wr(8'h03, 1);
    wait_dv(n + 1, 10, "order_dv1");
    chk("order_lat1", dv_cyc - wc, 2);
    chk_done_lat = 1;
    wait_dv(n + 3, 400, "order_dv3");
    repeat (110) tick();
    chk_done_lat = 0;
    chk("order_ndv", dv_count - n, 3);

    // Full and overflow with a stalled transmitter
    tx_en = 0;
    n = dv_count;
    o = ovf_cnt;
    for (int i = 0; i < 18; i++) wr(8'h80 + 8'(i), i < 17);
    repeat (2) tick();
    chk("ovf_count", o_Count, 16);
    chk("ovf_full", o_Full, 1);
    chk("ovf_empty", o_Empty, 0);
    chk("ovf_pulses", ovf_cnt - o, 1);
    chk("ovf_ndv", dv_count - n, 1);
    tx_en = 1;
    tx_delay = 2;
    kick_req++;
    wait_drain(500, "ovf_drain");
    repeat (10) tick();
    chk("ovf_drained", o_Empty, 1);

    // Wrap-around stream with backpressure
    n = dv_count;
    o = ovf_cnt;
    v = 0;
    g = 0;
    while (v < 40 && g < 2000) begin
      if (!o_Full) begin
        i_Wr_DV = 1'b1;
        i_Wr_Byte = 8'(v);
        exp_q.push_back(8'(v));
        v++;
      end else begin
        i_Wr_DV = 1'b0;
      end
      tick();
      g++;
    end
    i_Wr_DV = 1'b0;
    wait_drain(1000, "wrap_drain");
    repeat (10) tick();
    chk("wrap_ndv", dv_count - n, 40);
    chk("wrap_ovf", ovf_cnt - o, 0);

    // Flush while busy, with a simultaneous write dropped
    tx_en = 0;
    n = dv_count;
    o = ovf_cnt;
    for (int i = 0; i < 5; i++) wr(8'hC0 + 8'(i), 1);
    wait_dv(n + 1, 10, "flush_dv");
    exp_q.delete();
    i_Flush = 1'b1;
    i_Wr_DV = 1'b1;
    i_Wr_Byte = 8'hEE;
    tick();
    i_Flush = 1'b0;
    i_Wr_DV = 1'b0;
    chk("flush_count", o_Count, 0);
    chk("flush_empty", o_Empty, 1);
    chk("flush_full", o_Full, 0);
    chk("flush_byte", o_TX_Byte, 8'hC0);
    kick_req++;
    repeat (20) tick();
    chk("flush_ovf", ovf_cnt - o, 0);
    chk("flush_ndv", dv_count - n, 1);

    // Reset mid-operation
    n = dv_count;
    for (int i = 0; i < 5; i++) wr(8'hD0 + 8'(i), 1);
    wait_dv(n + 1, 10, "rst_mid_dv");
    i_Rst_L = 1'b0;
    #1;
    exp_q.delete();
    chk("rmid_dv", o_TX_DV, 0);
    chk("rmid_byte", o_TX_Byte, 8'h00);
    chk("rmid_full", o_Full, 0);
    chk("rmid_empty", o_Empty, 1);
    chk("rmid_count", o_Count, 0);
    chk("rmid_ovf", o_Overflow, 0);
    repeat (2) tick();
    i_Rst_L = 1'b1;
    repeat (20) tick();
    chk("rmid_nodv", dv_count - n, 1);
    tx_en = 1;
    tx_delay = 3;
    wc = cyc;
    wr(8'h3C, 1);
    wait_dv(n + 2, 10, "rmid_new_dv");
    chk("rmid_lat", dv_cyc - wc, 2);
    repeat (10) tick();
    chk("sb_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
